// File: rtl/dmem_pkg.sv
// Shared types for the data-memory DRAM port model.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package dmem_pkg;

    // Core ID tag carried with every request.
    localparam int TAG_W = 3;

    // Widest WIDTH the request struct can carry. Narrower ports zero-extend.
    localparam int REQ_W = 32;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_REFRESH = 1'b1
    } state_t;

    typedef struct packed {
        logic [REQ_W-1:0] addr;
        logic [REQ_W-1:0] data;
        logic             rd;
        logic             wr;
        logic [TAG_W-1:0] tag;
    } req_t;

    // Bits needed for a counter or index covering 0..n-1 (at least 1).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-return delay line of {valid, tag, data}, RD_LAT register stages.
// Latency: RD_LAT cycles from req_vld to rsp_vld.
// Backpressure: none; free-running, entries drain regardless of downstream.
//
// Ports: Clk, rst_n (async active-low); req_vld/req_tag/req_dat enter stage 0;
//        rsp_vld/rsp_tag/rsp_dat leave the last stage.
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             req_vld,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [WIDTH-1:0] req_dat,
    output logic             rsp_vld,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [WIDTH-1:0] rsp_dat
);

    logic [RD_LAT-1:0] vld_q;
    logic [TAG_W-1:0]  tag_q [RD_LAT];
    logic [WIDTH-1:0]  dat_q [RD_LAT];

    // Tag/data of a stage only move when the stage feeding it is valid, so the
    // last stage (and hence MEM/mem_tag) holds the last returned read.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= req_vld;
            if (req_vld) begin
                tag_q[0] <= req_tag;
                dat_q[0] <= req_dat;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    tag_q[i] <= tag_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rsp_vld = vld_q[RD_LAT-1];
    assign rsp_tag = tag_q[RD_LAT-1];
    assign rsp_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/dmem_dram_port.sv
// Single-port DRAM model behind the data-memory controller, with periodic refresh.
// Latency: reads return RD_LAT cycles after accept; wr_done pulses 1 cycle after accept.
// Backpressure: mem_ready drops for REF_CYC cycles every REFRESH_INT cycles; requester holds.
//
// Ports: Clk, rst_n (async active-low); request Addrs/DR/mread_en/mwrite_en/coreID;
//        mem_ready; read return MEM/mem_valid/mem_tag; write ack wr_done/wr_tag;
//        err (sticky, both enables seen on an accepted request).
module dmem_dram_port
    import dmem_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 256,
    parameter int RD_LAT      = 2,
    parameter int REFRESH_INT = 64,
    parameter int REF_CYC     = 2
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Addrs,
    input  logic [WIDTH-1:0] DR,
    input  logic             mread_en,
    input  logic             mwrite_en,
    input  logic [TAG_W-1:0] coreID,
    output logic             mem_ready,
    output logic [WIDTH-1:0] MEM,
    output logic             mem_valid,
    output logic [TAG_W-1:0] mem_tag,
    output logic             wr_done,
    output logic [TAG_W-1:0] wr_tag,
    output logic             err
);

    localparam int AW   = cnt_w(DEPTH);
    localparam int RC_W = cnt_w(REFRESH_INT);
    localparam int BC_W = cnt_w(REF_CYC);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    req_t             req;
    logic             accept;
    logic             do_wr;
    logic             do_rd;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] rd_dat;
    logic             unused_pad;

    always_comb begin
        req      = '0;
        req.addr = REQ_W'(Addrs);
        req.data = REQ_W'(DR);
        req.rd   = mread_en;
        req.wr   = mwrite_en;
        req.tag  = coreID;
    end

    // Upper data bits are zero padding from the fixed-width struct.
    assign unused_pad = ^req.data;

    assign accept = (req.rd | req.wr) & mem_ready;
    // A request with both enables is treated as a write; the read is dropped.
    assign do_wr  = accept & req.wr;
    assign do_rd  = accept & req.rd & ~req.wr;

    // Out-of-range addresses alias modulo DEPTH.
    assign idx = AW'(req.addr % REQ_W'(DEPTH));

    // ------------------------------------------------------------------
    // Storage array: no reset, contents survive rst_n.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_arr [DEPTH];

    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem_arr[idx] <= WIDTH'(req.data);
        end
    end

    // Combinational read; only one request per cycle, so a read never
    // collides with a write in the same cycle.
    assign rd_dat = mem_arr[idx];

    dmem_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .Clk     (Clk),
        .rst_n   (rst_n),
        .req_vld (do_rd),
        .req_tag (req.tag),
        .req_dat (rd_dat),
        .rsp_vld (mem_valid),
        .rsp_tag (mem_tag),
        .rsp_dat (MEM)
    );

    // ------------------------------------------------------------------
    // Refresh FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic [RC_W-1:0]   ref_cnt;
    logic [RC_W-1:0]   ref_cnt_nxt;
    logic [BC_W-1:0]   busy_cnt;
    logic [BC_W-1:0]   busy_cnt_nxt;
    logic              ready_nxt;
    logic              ref_expire;
    logic              busy_done;

    // REFRESH_INT of zero disables refresh entirely.
    assign ref_expire = (REFRESH_INT != 0) && (ref_cnt == RC_W'(REFRESH_INT - 1));
    assign busy_done  = (busy_cnt == BC_W'(REF_CYC - 1));

    // State register; mem_ready is registered so it tracks the state exactly.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ref_cnt   <= '0;
            busy_cnt  <= '0;
            mem_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            ref_cnt   <= ref_cnt_nxt;
            busy_cnt  <= busy_cnt_nxt;
            mem_ready <= ready_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        ref_cnt_nxt  = ref_cnt;
        busy_cnt_nxt = busy_cnt;
        case (state)
            ST_RUN: begin
                if (ref_expire) begin
                    state_nxt   = ST_REFRESH;
                    ref_cnt_nxt = '0;
                end else if (REFRESH_INT != 0) begin
                    ref_cnt_nxt = ref_cnt + RC_W'(1);
                end
            end
            ST_REFRESH: begin
                if (busy_done) begin
                    state_nxt    = ST_RUN;
                    busy_cnt_nxt = '0;
                end else begin
                    busy_cnt_nxt = busy_cnt + BC_W'(1);
                end
            end
        endcase
    end

    // Output logic: ready whenever the next state is RUN. A request on the
    // expiry cycle still sees mem_ready=1 and is accepted.
    always_comb begin
        ready_nxt = (state_nxt == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Write acknowledge and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_done <= 1'b0;
            wr_tag  <= '0;
            err     <= 1'b0;
        end else begin
            wr_done <= do_wr;
            if (do_wr) begin
                wr_tag <= req.tag;
            end
            if (accept && req.rd && req.wr) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dmem_dram_port.md
# dmem_dram_port

Single-port data-memory (DRAM model) that sits directly downstream of the multi-core data-memory controller. It consumes the controller's serialized request stream (address, write data, read/write enables, requesting core ID) and returns read data tagged with the core ID after a fixed pipeline latency. It also models periodic refresh, during which it withholds `mem_ready` so the controller must stall.

## Interface
- `WIDTH`, 8: data and address width in bits.
- `DEPTH`, 256: number of words; must be ≤ 2**WIDTH; addresses ≥ DEPTH alias modulo DEPTH.
- `RD_LAT`, 2: read latency in cycles, legal 1..4.
- `REFRESH_INT`, 64: cycles between refresh starts; 0 disables refresh.
- `REF_CYC`, 2: refresh busy length in cycles, ≥1.

- `Clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `Addrs`  in  WIDTH  request address from the controller.
- `DR`  in  WIDTH  write data.
- `mread_en`  in  1  read request.
- `mwrite_en`  in  1  write request.
- `coreID`  in  3  requesting core, carried as tag.
- `mem_ready`  out  1  port can accept a request this cycle.
- `MEM`  out  WIDTH  read data.
- `mem_valid`  out  1  one-cycle pulse: `MEM` and `mem_tag` are valid.
- `mem_tag`  out  3  coreID of the returned read.
- `wr_done`  out  1  one-cycle pulse, cycle after an accepted write.
- `wr_tag`  out  3  coreID of the completed write.
- `err`  out  1  sticky: a request had both enables set.

## Operation
- A request is accepted on a rising edge when (`mread_en` | `mwrite_en`) & `mem_ready`. Requests are ignored while `mem_ready`=0; the controller holds them.
- Write: the array word `Addrs mod DEPTH` is set to `DR` at the accept edge. `wr_done`/`wr_tag` pulse in the following cycle.
- Read: the array is read at the accept edge and pushed into an RD_LAT-deep pipe with tag and valid. It emerges as `MEM`/`mem_tag`/`mem_valid`.
- Both enables set: treat as write only, drop the read, and set `err` (cleared only by reset).
- FSM `RUN` → `REFRESH` → `RUN`:
  - In `RUN`, the refresh counter increments each cycle. When it equals REFRESH_INT-1, the next state is `REFRESH` and the counter clears.
  - In `REFRESH`, a busy counter runs REF_CYC cycles and `mem_ready`=0, then the FSM returns to `RUN`.
  - `mem_ready` is a registered output, high in `RUN`.
- Simultaneous request and counter expiry: the request is accepted, because `mem_ready` was high that cycle; refresh begins the next cycle.
- Reads in flight keep draining through the pipe during `REFRESH`.
- Array contents are not cleared by reset.

## Timing
- Reset values: `mem_ready`=1, `MEM`=0, `mem_valid`=0, `mem_tag`=0, `wr_done`=0, `wr_tag`=0, `err`=0, FSM=`RUN`, both counters 0, all pipe valid bits 0.
- Read accepted at edge T: `mem_valid`=1 during the cycle after edge T+RD_LAT-1. With RD_LAT=1, data is valid in the cycle immediately after acceptance.
- Throughput: one request per cycle while in `RUN`. Back-to-back reads produce back-to-back `mem_valid` pulses in order.
- Read-after-write to the same address on the next cycle returns the new data. The port is single-ported, so no same-cycle conflict exists.
- `MEM` holds its last value when `mem_valid`=0.
- Reset asserted mid-operation: in-flight reads are discarded with no `mem_valid`, refresh timing restarts from 0, and a pending `wr_done` is suppressed.

## Structure
- Shared package `dmem_pkg`: FSM state encoding (`ST_RUN`, `ST_REFRESH`), `TAG_W`=3, and a request struct (addr, data, rd, wr, tag).
- Sub-module `dmem_rd_pipe`: a parameterized RD_LAT-stage delay line of {valid, tag, data}, with async active-low reset on the valid bits.
- The top level holds the array, FSM, counters, and write-ack and error logic.

## Test plan
- Write, then read back: write 0xA5 to addr 0x10 with tag 2; read addr 0x10 with tag 3 (RD_LAT=2) → `wr_done`/`wr_tag`=2 the next cycle, then `mem_valid`=1, `MEM`=0xA5, `mem_tag`=3 two cycles after the read is accepted.
- Streaming: 4 consecutive reads of addrs 0..3, preloaded with 0x11..0x44 → 4 consecutive `mem_valid` pulses carrying 0x11, 0x22, 0x33, 0x44 in order, with tags matching.
- Refresh: REFRESH_INT=8, REF_CYC=2, requests held high → `mem_ready` low exactly 2 cycles out of every 10; no request is accepted while it is low; a request on the expiry cycle is accepted.
- Illegal request: `mread_en`=`mwrite_en`=1, addr 5, `DR`=0x7E → addr 5 becomes 0x7E, no `mem_valid`, `err`=1 and it stays 1.
- Reset mid-read: accept a read, then pulse `rst_n` low before the data returns → no `mem_valid`, all outputs at their reset values, `mem_ready`=1 immediately.
- RD_LAT=1 and RD_LAT=4 builds: latency is exactly 1 and 4 cycles respectively.
